// File: rtl/dut_bus_arbiter.sv
// rtl/dut_bus_arbiter.sv - two-requester round-robin arbiter for the DUT parallel data port
// Optional DUT_BUS_STRAY_CNT_EN adds stray_cnt_o, a saturating count of result pulses seen outside WAIT.

module dut_bus_arbiter #(
  parameter int DATA_W    = 8,
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_i,
  input  logic [1:0]            mode_i,
  input  logic [1:0]            rst_addr_i,
  input  logic [2*DATA_W-1:0]   data_i,
  output logic [1:0]            gnt_o,
  output logic [1:0]            rsp_v_o,
  output logic [DATA_W-1:0]     rsp_data_o,
  output logic                  rsp_err_o,
  output logic                  busy_o,
  output logic [DATA_W-1:0]     dut_data_o,
  output logic                  dut_data_v_o,
  output logic                  dut_mode_o,
  output logic                  dut_rst_addr_o,
  input  logic [DATA_W-1:0]     dut_res_i,
  input  logic                  dut_res_v_i
`ifdef DUT_BUS_STRAY_CNT_EN
  ,
  output logic [7:0]            stray_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t               state;
  logic                 ptr;
  logic                 owner;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 win;
  logic [DATA_W-1:0]    win_data;

  // On a tie the pointer side wins; a lone requester always wins.
  assign win      = (&req_i) ? ptr : req_i[1];
  assign win_data = win ? data_i[2*DATA_W-1:DATA_W] : data_i[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= 1'b0;
      owner          <= 1'b0;
      cnt            <= '0;
      gnt_o          <= 2'b00;
      rsp_v_o        <= 2'b00;
      rsp_data_o     <= '0;
      rsp_err_o      <= 1'b0;
      busy_o         <= 1'b0;
      dut_data_o     <= '0;
      dut_data_v_o   <= 1'b0;
      dut_mode_o     <= 1'b0;
      dut_rst_addr_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_i) begin
            owner          <= win;
            gnt_o          <= {win, ~win};
            dut_data_v_o   <= 1'b1;
            dut_data_o     <= win_data;
            dut_mode_o     <= mode_i[win];
            dut_rst_addr_o <= rst_addr_i[win];
            busy_o         <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          gnt_o          <= 2'b00;
          dut_data_v_o   <= 1'b0;
          dut_data_o     <= '0;
          dut_mode_o     <= 1'b0;
          dut_rst_addr_o <= 1'b0;
          // dut_mode_o still carries the latched mode during ISSUE.
          if (dut_mode_o) begin
            cnt   <= '0;
            state <= WAIT;
          end else begin
            ptr    <= ~owner;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (dut_res_v_i) begin
            rsp_v_o    <= {owner, ~owner};
            rsp_data_o <= dut_res_i;
            rsp_err_o  <= 1'b0;
            state      <= RESP;
          end else if (cnt == CNT_LAST) begin
            rsp_v_o    <= {owner, ~owner};
            rsp_data_o <= '0;
            rsp_err_o  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          rsp_v_o   <= 2'b00;
          rsp_err_o <= 1'b0;
          ptr       <= ~owner;
          busy_o    <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DUT_BUS_STRAY_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stray_cnt_o <= 8'h00;
    end else if (dut_res_v_i && (state != WAIT) && (stray_cnt_o != 8'hFF)) begin
      stray_cnt_o <= stray_cnt_o + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_dut_bus_arbiter.sv
// tb/tb_dut_bus_arbiter.sv - scoreboard bench for dut_bus_arbiter (TIMEOUT=16)

module tb_dut_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_i;
  logic [1:0]  mode_i;
  logic [1:0]  rst_addr_i;
  logic [15:0] data_i;
  logic [1:0]  gnt_o;
  logic [1:0]  rsp_v_o;
  logic [7:0]  rsp_data_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic [7:0]  dut_data_o;
  logic        dut_data_v_o;
  logic        dut_mode_o;
  logic        dut_rst_addr_o;
  logic [7:0]  dut_res_i;
  logic        dut_res_v_i;
`ifdef DUT_BUS_STRAY_CNT_EN
  logic [7:0]  stray_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_rsp;
    logic [1:0] oh;
    logic [7:0] d;
    logic       m;
    logic       ra;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  dut_bus_arbiter #(.DATA_W(8), .TIMEOUT_W(8), .TIMEOUT(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_i(req_i),
    .mode_i(mode_i),
    .rst_addr_i(rst_addr_i),
    .data_i(data_i),
    .gnt_o(gnt_o),
    .rsp_v_o(rsp_v_o),
    .rsp_data_o(rsp_data_o),
    .rsp_err_o(rsp_err_o),
    .busy_o(busy_o),
    .dut_data_o(dut_data_o),
    .dut_data_v_o(dut_data_v_o),
    .dut_mode_o(dut_mode_o),
    .dut_rst_addr_o(dut_rst_addr_o),
    .dut_res_i(dut_res_i),
    .dut_res_v_i(dut_res_v_i)
`ifdef DUT_BUS_STRAY_CNT_EN
    ,
    .stray_cnt_o(stray_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every gnt/rsp pulse must match the next expected event in order.
  always @(negedge clk) begin
    if ((gnt_o != 2'b00) || (rsp_v_o != 2'b00)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {28'd0, gnt_o, rsp_v_o}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_rsp)
          chk("rsp_event", {gnt_o, rsp_v_o, rsp_data_o, rsp_err_o},
              {2'b00, e.oh, e.d, e.err});
        else
          chk("gnt_event", {rsp_v_o, gnt_o, dut_data_v_o, dut_data_o, dut_mode_o, dut_rst_addr_o},
              {2'b00, e.oh, 1'b1, e.d, e.m, e.ra});
      end
    end
  end

  function automatic exp_t mk(input bit is_rsp, input logic [1:0] oh, input logic [7:0] d,
                              input logic m, input logic ra, input logic err);
    exp_t e;
    e.is_rsp = is_rsp; e.oh = oh; e.d = d; e.m = m; e.ra = ra; e.err = err;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_i = 2'b00; mode_i = 2'b00; rst_addr_i = 2'b00; data_i = 16'h0000;
    dut_res_i = 8'h00; dut_res_v_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input int r);
    int n = 0;
    while (!gnt_o[r] && n < 100) begin
      tick();
      n++;
    end
    chk("gnt_seen", {31'd0, gnt_o[r]}, 32'd1);
    req_i[r] = 1'b0;
  endtask

  task automatic pulse_res(input int dly, input logic [7:0] d);
    repeat (dly) tick();
    dut_res_v_i = 1'b1;
    dut_res_i   = d;
    tick();
    dut_res_v_i = 1'b0;
    dut_res_i   = 8'h00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 100) begin
      tick();
      n++;
    end
    chk("idle_reached", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    do_reset();
    chk("reset_outputs",
        {7'd0, gnt_o, rsp_v_o, rsp_data_o, rsp_err_o, busy_o, dut_data_o, dut_data_v_o, dut_mode_o, dut_rst_addr_o},
        32'd0);

    // Single write from req 0, exact latency
    exp_q.push_back(mk(0, 2'b01, 8'hA5, 0, 0, 0));
    req_i = 2'b01; mode_i = 2'b00; data_i = 16'hFFA5;
    tick();
    chk("t1_busy_issue", {30'd0, busy_o, dut_data_v_o}, 32'd3);
    req_i = 2'b00;
    tick();
    chk("t1_busy_low", {30'd0, busy_o, dut_data_v_o}, 32'd0);
    chk("t1_data_cleared", {24'd0, dut_data_o}, 32'd0);

    // Stray result in IDLE: ignored
    pulse_res(1, 8'h99);
    tick();
    chk("stray_no_busy", {31'd0, busy_o}, 32'd0);

    // Simultaneous reads, round robin
    do_reset();
    for (int p = 0; p < 2; p++) begin
      logic [7:0] r0, r1;
      r0 = (p == 0) ? 8'h11 : 8'h33;
      r1 = (p == 0) ? 8'h22 : 8'h44;
      exp_q.push_back(mk(0, 2'b01, 8'h40, 1, 0, 0));
      exp_q.push_back(mk(1, 2'b01, r0, 0, 0, 0));
      exp_q.push_back(mk(0, 2'b10, 8'h41, 1, 0, 0));
      exp_q.push_back(mk(1, 2'b10, r1, 0, 0, 0));
      req_i = 2'b11; mode_i = 2'b11; data_i = 16'h4140;
      wait_gnt(0);
      pulse_res(2, r0);
      wait_gnt(1);
      pulse_res(2, r1);
      wait_idle();
    end

    // Req 1 read, result 4 cycles after ISSUE, data held
    exp_q.push_back(mk(0, 2'b10, 8'h5A, 1, 0, 0));
    exp_q.push_back(mk(1, 2'b10, 8'h3C, 0, 0, 0));
    req_i = 2'b10; mode_i = 2'b10; data_i = 16'h5A00;
    wait_gnt(1);
    pulse_res(4, 8'h3C);
    wait_idle();
    repeat (3) tick();
    chk("t3_data_held", {23'd0, rsp_data_o, rsp_err_o}, {23'd0, 8'h3C, 1'b0});

    // Timeout after exactly 16 WAIT cycles
    begin
      int n = 0;
      exp_q.push_back(mk(0, 2'b01, 8'h07, 1, 0, 0));
      exp_q.push_back(mk(1, 2'b01, 8'h00, 0, 0, 1));
      req_i = 2'b01; mode_i = 2'b01; data_i = 16'h0007;
      wait_gnt(0);
      while (!rsp_v_o[0] && n < 100) begin
        tick();
        n++;
      end
      chk("t4_timeout_latency", n, 32'd17);
      chk("t4_err_flag", {31'd0, rsp_err_o}, 32'd1);
      tick();
      chk("t4_err_cleared", {23'd0, rsp_data_o, rsp_err_o}, 32'd0);
      wait_idle();
    end

    // Result on the last WAIT cycle beats the timeout
    exp_q.push_back(mk(0, 2'b01, 8'h08, 1, 0, 0));
    exp_q.push_back(mk(1, 2'b01, 8'h77, 0, 0, 0));
    req_i = 2'b01; mode_i = 2'b01; data_i = 16'h0008;
    wait_gnt(0);
    pulse_res(16, 8'h77);
    wait_idle();

    // Reset during WAIT abandons the read
    exp_q.push_back(mk(0, 2'b01, 8'h09, 1, 0, 0));
    req_i = 2'b01; mode_i = 2'b01; data_i = 16'h0009;
    wait_gnt(0);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("t5_reset_outputs",
        {7'd0, gnt_o, rsp_v_o, rsp_data_o, rsp_err_o, busy_o, dut_data_o, dut_data_v_o, dut_mode_o, dut_rst_addr_o},
        32'd0);
    rst_n = 1'b1;
    repeat (25) tick();
    chk("t5_no_rsp_pending", exp_q.size(), 32'd0);

    exp_q.push_back(mk(0, 2'b10, 8'hC3, 0, 0, 0));
    req_i = 2'b10; mode_i = 2'b00; data_i = 16'hC3FF;
    wait_gnt(1);
    wait_idle();

    exp_q.push_back(mk(0, 2'b01, 8'h2E, 0, 1, 0));
    req_i = 2'b01; mode_i = 2'b00; rst_addr_i = 2'b11; data_i = 16'h992E;
    wait_gnt(0);
    rst_addr_i = 2'b00;
    wait_idle();

`ifdef DUT_BUS_STRAY_CNT_EN
    do_reset();
    chk("t6_stray_reset", {24'd0, stray_cnt_o}, 32'd0);
    for (int i = 0; i < 3; i++) pulse_res(1, 8'h10);
    tick();
    chk("t6_stray_three", {24'd0, stray_cnt_o}, 32'd3);
    chk("t6_stray_idle", {31'd0, busy_o}, 32'd0);
    dut_res_v_i = 1'b1;
    repeat (300) tick();
    dut_res_v_i = 1'b0;
    tick();
    chk("t6_stray_sat", {24'd0, stray_cnt_o}, 32'hFF);
`endif

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
